// File: rtl/mysystem_timer_pkg.sv
// Shared definitions for the multi-channel interval timer.
// Holds the per-channel register index map, CONTROL/STATUS bit positions
// and a helper that sizes the channel-select field of the address.
package mysystem_timer_pkg;

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_SNAP     = 3'd3,
    REG_PRESCALE = 3'd4,
    REG_IRQ_PEND = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_e;

  // CONTROL write bits; START/STOP are strobes and never stored
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  // STATUS read bits
  localparam int STS_TO  = 0;
  localparam int STS_RUN = 1;

  // channel-select bits; a single channel still gets one address bit
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mysystem_multi_timer_if.sv
// Avalon-MM slave bus of the multi-channel timer, plus its interrupt outputs.
//   address    {channel, reg}, reg = address[2:0]
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   registered read data (1-cycle latency)
//   irq        OR of irq_vec
//   irq_vec    per-channel interrupt
interface mysystem_multi_timer_if #(
  parameter int NUM_CH = 4
);
  import mysystem_timer_pkg::*;
  localparam int CH_W = ch_bits(NUM_CH);

  logic [CH_W+2:0]   address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq, irq_vec
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq, irq_vec
  );

endinterface

// File: rtl/mysystem_timer_channel.sv
// One timer channel: prescaler, down-counter, PERIOD/PRESCALE/CONTROL/SNAP
// registers, sticky TO, RUN and the channel interrupt.
//   clk, reset_n  clock, async active-low reset
//   wr_en         write strobe already decoded for this channel
//   reg_sel       register index of the write
//   wdata         write data (upper bits beyond CNT_W/PRE_W ignored)
//   to, run, cont, ito, period, snap, prescale  register state for readback
//   irq           TO & ITO
module mysystem_timer_channel
  import mysystem_timer_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int          PRE_W      = 8,
  parameter int unsigned RST_PERIOD = 49999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  reg_e             reg_sel,
  input  logic [31:0]      wdata,
  output logic             to,
  output logic             run,
  output logic             cont,
  output logic             ito,
  output logic             irq,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap,
  output logic [PRE_W-1:0] prescale
);

  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RST_PERIOD);

  logic [CNT_W-1:0] cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic             force_reload;
  logic             wr_sts, wr_ctl, wr_per, wr_snap, wr_pre;
  logic             tick, timeout, start, stop;

  assign wr_sts  = wr_en && (reg_sel == REG_STATUS);
  assign wr_ctl  = wr_en && (reg_sel == REG_CONTROL);
  assign wr_per  = wr_en && (reg_sel == REG_PERIOD);
  assign wr_snap = wr_en && (reg_sel == REG_SNAP);
  assign wr_pre  = wr_en && (reg_sel == REG_PRESCALE);
  assign start   = wr_ctl && wdata[CTL_START];
  assign stop    = wr_ctl && wdata[CTL_STOP];

  // the reload cycle owns the counter, so no tick (and no timeout) there
  assign tick    = run && !force_reload && (pre_cnt == prescale);
  assign timeout = tick && (cnt == '0);
  assign irq     = to & ito;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= RST_CNT;
      period       <= RST_CNT;
      prescale     <= '0;
      pre_cnt      <= '0;
      snap         <= '0;
      cont         <= 1'b0;
      ito          <= 1'b0;
      to           <= 1'b0;
      run          <= 1'b0;
      force_reload <= 1'b0;
    end else begin
      force_reload <= wr_per;
      if (wr_per) period   <= wdata[CNT_W-1:0];
      if (wr_pre) prescale <= wdata[PRE_W-1:0];
      if (wr_ctl) begin
        cont <= wdata[CTL_CONT];
        ito  <= wdata[CTL_ITO];
      end
      // captures the value before any decrement on this edge
      if (wr_snap) snap <= cnt;

      if (force_reload)  cnt <= period;
      else if (tick)     cnt <= (cnt == '0) ? period : cnt - 1'b1;

      if (wr_pre || force_reload || !run || tick) pre_cnt <= '0;
      else                                        pre_cnt <= pre_cnt + 1'b1;

      // START beats STOP, reload and one-shot expiry
      if (start)                                     run <= 1'b1;
      else if (stop || force_reload || (timeout && !cont)) run <= 1'b0;

      // a STATUS write beats a coincident timeout
      if (wr_sts)       to <= 1'b0;
      else if (timeout) to <= 1'b1;
    end
  end

endmodule

// File: rtl/mysystem_multi_timer.sv
// Multi-channel Avalon-MM interval timer. Decodes {channel, reg} addresses,
// fans writes out to NUM_CH channel instances and registers read data every
// cycle from the current address (chipselect not required for reads).
//   clk, reset_n  clock, async active-low reset
//   bus           Avalon-MM slave: address/chipselect/write_n/writedata,
//                 readdata, irq, irq_vec
module mysystem_multi_timer
  import mysystem_timer_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter int          PRE_W      = 8,
  parameter int unsigned RST_PERIOD = 49999
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mysystem_multi_timer_if.slave bus
);

  localparam int CH_W = ch_bits(NUM_CH);

  logic [CH_W-1:0] ch_sel;
  reg_e            reg_sel;
  logic            ch_ok, wr;
  logic [31:0]     rd_q;

  logic [NUM_CH-1:0]            to_v, run_v, cont_v, ito_v, irq_v;
  logic [NUM_CH-1:0][CNT_W-1:0] period_v, snap_v;
  logic [NUM_CH-1:0][PRE_W-1:0] pre_v;

  assign ch_sel  = bus.address[CH_W+2:3];
  assign reg_sel = reg_e'(bus.address[2:0]);
  // channel indices past NUM_CH are holes in the map
  assign ch_ok   = 32'(ch_sel) < 32'(NUM_CH);
  assign wr      = bus.chipselect & ~bus.write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mysystem_timer_channel #(
      .CNT_W      (CNT_W),
      .PRE_W      (PRE_W),
      .RST_PERIOD (RST_PERIOD)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr && ch_ok && (ch_sel == CH_W'(i))),
      .reg_sel  (reg_sel),
      .wdata    (bus.writedata),
      .to       (to_v[i]),
      .run      (run_v[i]),
      .cont     (cont_v[i]),
      .ito      (ito_v[i]),
      .irq      (irq_v[i]),
      .period   (period_v[i]),
      .snap     (snap_v[i]),
      .prescale (pre_v[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= '0;
      if (ch_ok) begin
        case (reg_sel)
          REG_STATUS: begin
            rd_q[STS_TO]  <= to_v[ch_sel];
            rd_q[STS_RUN] <= run_v[ch_sel];
          end
          REG_CONTROL: begin
            rd_q[CTL_ITO]  <= ito_v[ch_sel];
            rd_q[CTL_CONT] <= cont_v[ch_sel];
          end
          REG_PERIOD:   rd_q <= 32'(period_v[ch_sel]);
          REG_SNAP:     rd_q <= 32'(snap_v[ch_sel]);
          REG_PRESCALE: rd_q <= 32'(pre_v[ch_sel]);
          REG_IRQ_PEND: rd_q <= 32'(irq_v);
          default:      rd_q <= '0;
        endcase
      end
    end
  end

  assign bus.readdata = rd_q;
  assign bus.irq_vec  = irq_v;
  assign bus.irq      = |irq_v;

endmodule
